// File: rtl/koopa_sprite_render_if.sv
// koopa_sprite_render_if: pixel scan input, sprite ROM port and compositor
// output of the koopa sprite renderer, bundled as one bus.
// The slave modport is the renderer. The master modport is the scan/ROM/compositor side.
interface koopa_sprite_render_if #(
    parameter int ADDR_W = 16
);
    logic              pix_valid;
    logic [9:0]        pix_x;
    logic [9:0]        pix_y;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              out_valid;
    logic [7:0]        out_pixel;
    logic              out_opaque;

    modport slave (
        input  pix_valid,
        input  pix_x,
        input  pix_y,
        output rom_addr,
        input  rom_data,
        output out_valid,
        output out_pixel,
        output out_opaque
    );

    modport master (
        output pix_valid,
        output pix_x,
        output pix_y,
        input  rom_addr,
        output rom_data,
        input  out_valid,
        input  out_pixel,
        input  out_opaque
    );
endinterface

// File: rtl/koopa_sprite_render.sv
// koopa_sprite_render: per-pixel sprite hit test and sprite-sheet ROM lookup.
// Three-stage pipeline. Stage 1 does the hit test and registers the ROM address.
// Stage 2 waits for the synchronous ROM. Stage 3 registers the colour and opaque flag.
// The frame origin, screen position and facing are shadowed on frame_start. A
// mid-frame animation step therefore cannot tear the sprite.
// Optional feature macro: KOOPA_SPRITE_FLIP_EN (horizontal mirroring on facing_left).
module koopa_sprite_render #(
    parameter int         SPRITE_W    = 23,
    parameter int         SPRITE_H    = 30,
    parameter int         SHEET_W     = 256,
    parameter int         ADDR_W      = 16,
    parameter logic [7:0] TRANSPARENT = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic [10:0] anim_row,
    input  logic [10:0] anim_col,
    input  logic [9:0]  sprite_x,
    input  logic [9:0]  sprite_y,
    input  logic        facing_left,
    koopa_sprite_render_if.slave bus
);

    localparam logic [9:0]  SPR_W_C  = 10'(SPRITE_W);
    localparam logic [9:0]  SPR_H_C  = 10'(SPRITE_H);
    localparam logic [21:0] SHEET_C  = 22'(SHEET_W);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t state_r;
    state_t state_next_s;
    logic   armed_s;

    logic [10:0] l_anim_row_r;
    logic [10:0] l_anim_col_r;
    logic [9:0]  l_sprite_x_r;
    logic [9:0]  l_sprite_y_r;

    logic [10:0] dx_s;
    logic [10:0] dy_s;
    logic        hit_s;
    logic [9:0]  lc_s;
    logic [21:0] row_sum_s;
    logic [21:0] addr_full_s;

    logic [ADDR_W-1:0] rom_addr_r;
    logic              s1_valid_r;
    logic              s1_hit_r;
    logic              s2_valid_r;
    logic              s2_hit_r;
    logic              opaque_s;
    logic              out_valid_r;
    logic              out_opaque_r;
    logic [7:0]        out_pixel_r;

    // FSM state register: EMPTY until the first frame has been latched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: the first frame_start arms the renderer. Only reset can disarm it.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            EMPTY:   state_next_s = frame_start ? ARMED : EMPTY;
            ARMED:   state_next_s = ARMED;
            default: state_next_s = EMPTY;
        endcase
    end

    // FSM outputs: pixels can only hit once a frame is latched.
    always_comb begin
        armed_s = 1'b0;
        if (state_r == ARMED) begin
            armed_s = 1'b1;
        end else begin
            armed_s = 1'b0;
        end
    end

    // Shadow registers: written only on frame_start. A same-cycle pixel still sees the old frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            l_anim_row_r <= 11'd0;
            l_anim_col_r <= 11'd0;
            l_sprite_x_r <= 10'd0;
            l_sprite_y_r <= 10'd0;
        end else if (frame_start) begin
            l_anim_row_r <= anim_row;
            l_anim_col_r <= anim_col;
            l_sprite_x_r <= sprite_x;
            l_sprite_y_r <= sprite_y;
        end else begin
            l_anim_row_r <= l_anim_row_r;
            l_anim_col_r <= l_anim_col_r;
            l_sprite_x_r <= l_sprite_x_r;
            l_sprite_y_r <= l_sprite_y_r;
        end
    end

`ifdef KOOPA_SPRITE_FLIP_EN
    logic l_facing_left_r;

    // Facing shadow register: latched with the rest of the frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            l_facing_left_r <= 1'b0;
        end else if (frame_start) begin
            l_facing_left_r <= facing_left;
        end else begin
            l_facing_left_r <= l_facing_left_r;
        end
    end

    // Column select: mirror within the frame when facing left.
    always_comb begin
        lc_s = dx_s[9:0];
        if (l_facing_left_r) begin
            lc_s = (SPR_W_C - 10'd1) - dx_s[9:0];
        end else begin
            lc_s = dx_s[9:0];
        end
    end
`else
    logic facing_unused_s;
    assign facing_unused_s = facing_left;

    // Column select: no mirroring in this build.
    always_comb begin
        lc_s = dx_s[9:0];
    end
`endif

    // Stage 1 hit test. The offsets are 11-bit signed, so a pixel left of or above
    // the sprite has its sign bit set and cannot wrap into a hit.
    always_comb begin
        dx_s        = {1'b0, bus.pix_x} - {1'b0, l_sprite_x_r};
        dy_s        = {1'b0, bus.pix_y} - {1'b0, l_sprite_y_r};
        hit_s       = armed_s
                      && !dx_s[10] && (dx_s[9:0] < SPR_W_C)
                      && !dy_s[10] && (dy_s[9:0] < SPR_H_C);
        row_sum_s   = 22'(l_anim_row_r) + 22'(dy_s[9:0]);
        addr_full_s = row_sum_s * SHEET_C + 22'(l_anim_col_r) + 22'(lc_s);
    end

    // Stage 1 registers: the ROM address moves only on a real hit. Valid and hit travel alongside.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr_r <= '0;
            s1_valid_r <= 1'b0;
            s1_hit_r   <= 1'b0;
        end else begin
            if (bus.pix_valid && hit_s) begin
                rom_addr_r <= addr_full_s[ADDR_W-1:0];
            end else begin
                rom_addr_r <= rom_addr_r;
            end
            s1_valid_r <= bus.pix_valid;
            s1_hit_r   <= bus.pix_valid && hit_s;
        end
    end

    // Stage 2 registers: cover the synchronous ROM read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_r <= 1'b0;
            s2_hit_r   <= 1'b0;
        end else begin
            s2_valid_r <= s1_valid_r;
            s2_hit_r   <= s1_hit_r;
        end
    end

    // Colour key test on the returned ROM data.
    always_comb begin
        opaque_s = 1'b0;
        if (s2_hit_r && (bus.rom_data != TRANSPARENT)) begin
            opaque_s = 1'b1;
        end else begin
            opaque_s = 1'b0;
        end
    end

    // Stage 3 output registers: the pixel is forced to zero whenever it is not opaque.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r  <= 1'b0;
            out_opaque_r <= 1'b0;
            out_pixel_r  <= 8'h00;
        end else begin
            out_valid_r  <= s2_valid_r;
            out_opaque_r <= opaque_s;
            out_pixel_r  <= opaque_s ? bus.rom_data : 8'h00;
        end
    end

    assign bus.rom_addr   = rom_addr_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_opaque = out_opaque_r;
    assign bus.out_pixel  = out_pixel_r;

endmodule

// File: tb/tb_koopa_sprite_render.sv
// tb_koopa_sprite_render: directed bench for koopa_sprite_render. It includes a
// synchronous ROM model whose data depends on the address.
module tb_koopa_sprite_render;

    logic        clk;
    logic        reset_n;
    logic        frame_start;
    logic [10:0] anim_row;
    logic [10:0] anim_col;
    logic [9:0]  sprite_x;
    logic [9:0]  sprite_y;
    logic        facing_left;
    int          total;
    int          bad;
    logic [7:0]  pat;
    logic        exp_v;

    koopa_sprite_render_if #(.ADDR_W(16)) bus ();

    koopa_sprite_render dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .anim_row    (anim_row),
        .anim_col    (anim_col),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .facing_left (facing_left),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sprite-sheet contents: two fixed entries. Elsewhere the data is the low address byte with bit 0 forced to 1, so it is never transparent.
    function automatic logic [7:0] rom_fn(input logic [15:0] a);
        if (a == 16'd23063)      return 8'h3C;
        else if (a == 16'd23064) return 8'h00;
        else                     return a[7:0] | 8'h01;
    endfunction

    // Synchronous ROM: data is valid one cycle after the address.
    always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_frame(input logic [10:0] r, input logic [10:0] c,
                            input logic [9:0] x, input logic [9:0] y, input logic f);
        @(negedge clk);
        anim_row = r; anim_col = c; sprite_x = x; sprite_y = y; facing_left = f;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // One isolated pixel: address after 1 cycle, bubble at +2, result at +3.
    task automatic run_pixel(input logic [9:0] x, input logic [9:0] y,
                             input logic [15:0] ea, input logic eo,
                             input logic [7:0] ep, input string tag);
        @(negedge clk);
        bus.pix_valid = 1'b1; bus.pix_x = x; bus.pix_y = y;
        @(negedge clk);
        bus.pix_valid = 1'b0;
        chk({tag, "_addr"}, 32'(bus.rom_addr), 32'(ea));
        @(negedge clk);
        chk({tag, "_early"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_opq"}, 32'(bus.out_opaque), 32'(eo));
        chk({tag, "_pix"}, 32'(bus.out_pixel), 32'(ep));
    endtask

    initial begin
        total = 0; bad = 0;
        reset_n = 1'b0; frame_start = 1'b0;
        anim_row = 11'd0; anim_col = 11'd0; sprite_x = 10'd0; sprite_y = 10'd0;
        facing_left = 1'b0;
        bus.pix_valid = 1'b0; bus.pix_x = 10'd0; bus.pix_y = 10'd0;
        repeat (2) @(negedge clk);
        chk("rst_addr", 32'(bus.rom_addr), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_opq", 32'(bus.out_opaque), 32'd0);
        chk("rst_pix", 32'(bus.out_pixel), 32'd0);
        reset_n = 1'b1;

        // Before any frame: out_valid trails pix_valid by 3 and every pixel misses.
        // The latched origin is (0,0), so pixel (5,5) would hit if the design were armed.
        pat = 8'b1011_0110;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            exp_v = (i >= 3 && i < 11) ? pat[i-3] : 1'b0;
            chk("pre_valid", 32'(bus.out_valid), 32'(exp_v));
            chk("pre_opq", 32'(bus.out_opaque), 32'd0);
            chk("pre_pix", 32'(bus.out_pixel), 32'd0);
            chk("pre_addr", 32'(bus.rom_addr), 32'd0);
            bus.pix_valid = (i < 8) ? pat[i] : 1'b0;
            bus.pix_x = 10'd5; bus.pix_y = 10'd5;
        end
        bus.pix_valid = 1'b0;
        @(negedge clk);

        // Main function: origin, far corner, misses at each edge, and the colour key.
        do_frame(11'd90, 11'd23, 10'd100, 10'd50, 1'b0);
        run_pixel(10'd100, 10'd50, 16'd23063, 1'b1, 8'h3C, "origin");
        run_pixel(10'd122, 10'd79, 16'd30509, 1'b1, 8'h2D, "corner");
        run_pixel(10'd99,  10'd50, 16'd30509, 1'b0, 8'h00, "left_m1");
        run_pixel(10'd123, 10'd50, 16'd30509, 1'b0, 8'h00, "right_w");
        run_pixel(10'd100, 10'd80, 16'd30509, 1'b0, 8'h00, "below_h");
        run_pixel(10'd101, 10'd50, 16'd23064, 1'b0, 8'h00, "transp");

        // Changing the inputs mid-frame without frame_start has no effect.
        anim_row = 11'd120;
        run_pixel(10'd100, 10'd50, 16'd23063, 1'b1, 8'h3C, "midframe");

        // frame_start in the same cycle as a pixel: that pixel uses the old frame, the next one the new frame.
        @(negedge clk);
        frame_start = 1'b1; bus.pix_valid = 1'b1; bus.pix_x = 10'd100; bus.pix_y = 10'd50;
        @(negedge clk);
        frame_start = 1'b0;
        chk("fs_old_addr", 32'(bus.rom_addr), 32'd23063);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        chk("fs_new_addr", 32'(bus.rom_addr), 32'd30743);
        @(negedge clk);
        chk("fs_old_pix", 32'(bus.out_pixel), 32'h3C);
        chk("fs_old_opq", 32'(bus.out_opaque), 32'd1);
        @(negedge clk);
        chk("fs_new_valid", 32'(bus.out_valid), 32'd1);
        chk("fs_new_pix", 32'(bus.out_pixel), 32'h17);

        // Facing left: the column is mirrored only when the flip feature is built.
        do_frame(11'd90, 11'd23, 10'd100, 10'd50, 1'b1);
`ifdef KOOPA_SPRITE_FLIP_EN
        run_pixel(10'd100, 10'd50, 16'd23085, 1'b1, 8'h2D, "flip_org");
        run_pixel(10'd122, 10'd79, 16'd30487, 1'b1, 8'h17, "flip_cor");
`else
        run_pixel(10'd100, 10'd50, 16'd23063, 1'b1, 8'h3C, "noflip_org");
        run_pixel(10'd122, 10'd79, 16'd30509, 1'b1, 8'h2D, "noflip_cor");
`endif

        // Sprite at the right screen edge clips; x=0 must not wrap into a hit.
        do_frame(11'd90, 11'd23, 10'd1010, 10'd50, 1'b0);
        run_pixel(10'd1023, 10'd50, 16'd23076, 1'b1, 8'h25, "clip_in");
        run_pixel(10'd0,    10'd50, 16'd23076, 1'b0, 8'h00, "clip_wrap");
        run_pixel(10'd1009, 10'd50, 16'd23076, 1'b0, 8'h00, "clip_m1");

        // Reset with pixels in flight clears the outputs at once and disarms the renderer.
        do_frame(11'd90, 11'd23, 10'd100, 10'd50, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.pix_valid = 1'b1; bus.pix_x = 10'(100 + i); bus.pix_y = 10'd50;
        end
        @(negedge clk);
        bus.pix_valid = 1'b0;
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_addr", 32'(bus.rom_addr), 32'd0);
        chk("async_valid", 32'(bus.out_valid), 32'd0);
        chk("async_opq", 32'(bus.out_opaque), 32'd0);
        chk("async_pix", 32'(bus.out_pixel), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_idle", 32'(bus.out_valid), 32'd0);
        end
        run_pixel(10'd100, 10'd50, 16'd0, 1'b0, 8'h00, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/koopa_sprite_render.md
# koopa_sprite_render

Pixel-side consumer of the koopa animation FSMs' `anim_row`/`anim_col` sprite-sheet origin. For each pixel the scan logic presents, it decides whether that pixel lies inside the character sprite. On a hit it addresses the synchronous sprite-sheet ROM and returns the colour plus an opaque flag to the compositor. Frame origin, screen position and facing are latched once per video frame, so a mid-frame `anim_tick` never tears the sprite.

## Interface
- `SPRITE_W`, 23: frame width in sheet pixels.
- `SPRITE_H`, 30: frame height in sheet pixels.
- `SHEET_W`, 256: sheet row stride in pixels.
- `ADDR_W`, 16: ROM address width.
- `TRANSPARENT`, 8'h00: colour key treated as see-through.

Ports:
- `clk` in 1: system clock; single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `frame_start` in 1: one-cycle pulse at the start of vertical blank; latches the shadow inputs.
- `anim_row` in 11: sheet row of the current frame origin, from the animation FSM.
- `anim_col` in 11: sheet column of the current frame origin, from the animation FSM.
- `sprite_x` in 10: screen x of the sprite's top-left corner.
- `sprite_y` in 10: screen y of the sprite's top-left corner.
- `facing_left` in 1: 1 mirrors the sprite horizontally.
- `pix_valid` in 1: qualifies `pix_x`/`pix_y`.
- `pix_x` in 10: scan x of the current pixel.
- `pix_y` in 10: scan y of the current pixel.
- `rom_addr` out ADDR_W: sprite ROM address (registered).
- `rom_data` in 8: ROM read data, valid one cycle after `rom_addr`.
- `out_valid` out 1: qualifies `out_pixel`/`out_opaque`.
- `out_pixel` out 8: sprite colour; 0 when `out_opaque`=0.
- `out_opaque` out 1: 1 means the compositor draws `out_pixel` over the background.

## Operation
- FSM states:
  - EMPTY: reset state; no frame latched yet.
  - ARMED: a frame is latched.
  - EMPTY→ARMED on the first `frame_start`. There is no exit from ARMED except reset.
  - In EMPTY every pixel result is a miss.
- Latch: on `frame_start`, capture `anim_row`, `anim_col`, `sprite_x`, `sprite_y` and `facing_left` into the `L_` registers. These registers are not otherwise written.
- Stage 1 (pixel in):
  - dx = `pix_x` − L_sprite_x and dy = `pix_y` − L_sprite_y, computed as 11-bit signed values.
  - hit = ARMED, dx ≥ 0, dx < SPRITE_W, dy ≥ 0 and dy < SPRITE_H.
  - lc = L_facing_left ? SPRITE_W−1−dx : dx.
  - `rom_addr` ← (L_anim_row+dy)·SHEET_W + L_anim_col + lc, truncated to ADDR_W. Intermediate width is at least 22 bits.
  - On a miss, `rom_addr` holds its previous value.
- Stage 2: the ROM returns data; hit and valid are carried alongside.
- Stage 3 (registered outputs):
  - `out_valid` ← carried valid.
  - `out_opaque` ← hit && `rom_data` ≠ TRANSPARENT.
  - `out_pixel` ← `out_opaque` ? `rom_data` : 0.
- Bubbles: when `pix_valid`=0, a bubble is inserted and the pipeline advances every cycle. There is no stall or backpressure.

## Timing
- Reset values:
  - `rom_addr`=0, `out_valid`=0, `out_pixel`=0, `out_opaque`=0.
  - All pipeline valid and hit bits = 0.
  - `L_` registers = 0.
  - State = EMPTY.
- Reset takes effect immediately (asynchronous). Release is used synchronously on the next `clk` edge.
- Latency: `pix_valid` at cycle N gives `rom_addr` at N+1 and `out_valid`/`out_pixel`/`out_opaque` at N+3.
- Throughput: one pixel per clock.
- `frame_start` together with `pix_valid` in the same cycle: that pixel uses the old latched values. The new values apply from N+1.
- `anim_row`/`anim_col`/`sprite_*` changing between `frame_start` pulses has no effect on output.
- Edges: dx = SPRITE_W or dy = SPRITE_H is a miss. dx = −1 (pixel left of the sprite) is a miss; it must not be treated as an unsigned wrap into a hit.
- Sprite at the screen edge: `sprite_x`+SPRITE_W > 1023 simply clips. Nothing wraps to x=0.
- Reset mid-stream: in-flight pixels are dropped; `out_valid` is 0 until 3 cycles after the first post-reset `pix_valid`.

## Configuration
- `KOOPA_SPRITE_FLIP_EN` defined: `facing_left` is latched and mirrors the column as specified above.
- Not defined:
  - The `facing_left` port remains but is ignored; lc = dx always.
  - The flip subtractor is not built.

## Test plan
- Reset, then drive pixels before any `frame_start` -> `out_valid` follows `pix_valid` by 3 cycles; `out_opaque`=0, `out_pixel`=0, `rom_addr`=0.
- Latch anim_row=90, anim_col=23, sprite (100,50), facing 0; pixel (100,50) -> `rom_addr`=23063 at N+1; with `rom_data`=8'h3C, output is pixel 8'h3C, opaque 1 at N+3.
- Same setup; pixel (122,79) -> `rom_addr` = (90+29)·256 + 23 + 22 = 30509. With FLIP_EN and facing_left=1, pixel (100,50) -> `rom_addr`=23085.
- Pixels (99,50), (123,50) and (100,80) -> opaque 0, pixel 0. In-sprite pixel with `rom_data`=8'h00 -> opaque 0.
- Mid-frame change to anim_row=120 without `frame_start` -> address unchanged. Then pulse `frame_start` together with pixel (100,50) -> that pixel gives 23063; the next pixel (100,50) gives 30743.
- Assert `reset_n`=0 with three pixels in flight -> all outputs 0 immediately. After release, state is EMPTY and results are misses until the next `frame_start`.
